// File: rtl/bias_sweep_seq.sv
// bias_sweep_seq: programmable hold/up/down/triangle bias sweep sequencer with start/abort/done handshake
module bias_sweep_seq #(
    parameter int IB_W = 8,
    parameter int IDAC_W = 4,
    parameter int DIODE_N = 8,
    parameter int RES_DIV = 1,
    parameter logic [IB_W-1:0] IB_INIT = 8'h7F,
    parameter logic [IDAC_W-1:0] IDAC_INIT = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [IB_W-1:0]    ib_lo,
    input  logic [IB_W-1:0]    ib_hi,
    input  logic [IB_W-1:0]    step,
    input  logic [15:0]        dwell,
    input  logic [DIODE_N-1:0] diode_mask,
    output logic [IB_W-1:0]    ib,
    output logic [IB_W-1:0]    ibf,
    output logic               res_n,
    output logic [DIODE_N-1:0] diode,
    output logic [IDAC_W-1:0]  idac_o,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int RW = $clog2(RES_DIV + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic rst_q, dir;
    logic [15:0] dcnt, dw_q;
    logic [IB_W-1:0] lo_q, hi_q, step_q, up_val, dn_val, next_ib;
    logic [1:0] mode_q;
    logic [RW-1:0] res_cnt;
    logic [IB_W:0] up_sum, dn_dif;
    logic cfg_bad, finish, flip;
    always_comb begin
        up_sum  = {1'b0, ib} + {1'b0, step_q};
        dn_dif  = {1'b0, ib} - {1'b0, step_q};
        up_val  = up_sum > {1'b0, hi_q} ? hi_q : up_sum[IB_W-1:0];
        dn_val  = (dn_dif[IB_W] || dn_dif[IB_W-1:0] < lo_q) ? lo_q : dn_dif[IB_W-1:0];
        flip    = mode_q == 2'd3 && !dir && ib == hi_q;
        next_ib = (dir || flip) ? dn_val : up_val;
        finish  = mode_q == 2'd0 || (mode_q == 2'd1 && ib == hi_q) ||
                  (mode_q[1] && dir && ib == lo_q);
        cfg_bad = ib_lo > ib_hi || (step == '0 && mode != 2'd0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_q <= 1'b1;
        else rst_q <= 1'b0;
    end
    // rst_q rises with reset and falls one clk after release, so the block stays in reset through that edge
    always_ff @(posedge clk or posedge rst_q) begin
        if (rst_q) begin
            state   <= IDLE;
            ib      <= IB_INIT;
            ibf     <= '0;
            res_n   <= 1'b1;
            diode   <= '1;
            idac_o  <= IDAC_INIT;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dir     <= 1'b0;
            dcnt    <= '0;
            dw_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            res_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    if (cfg_bad) err <= 1'b1;
                    else begin
                        ib      <= mode == 2'd2 ? ib_hi : ib_lo;
                        ibf     <= '0;
                        dcnt    <= dwell == 16'd0 ? 16'd0 : dwell - 16'd1;
                        dw_q    <= dwell == 16'd0 ? 16'd0 : dwell - 16'd1;
                        diode   <= diode_mask;
                        dir     <= mode == 2'd2;
                        lo_q    <= ib_lo;
                        hi_q    <= ib_hi;
                        step_q  <= step;
                        mode_q  <= mode;
                        res_n   <= 1'b1;
                        res_cnt <= RW'(RES_DIV - 1);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: if (abort) begin
                    ib    <= IB_INIT;
                    res_n <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    ibf     <= ibf + 1'b1;
                    res_cnt <= res_cnt == '0 ? RW'(RES_DIV - 1) : res_cnt - 1'b1;
                    res_n   <= res_cnt == '0 ? ~res_n : res_n;
                    dcnt    <= dcnt == 16'd0 ? dw_q : dcnt - 16'd1;
                    if (dcnt == 16'd0) begin
                        if (finish) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            res_n  <= 1'b1;
                            idac_o <= idac_o + 1'b1;
                        end else begin
                            ib  <= next_ib;
                            dir <= dir | flip;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (abort) ib <= IB_INIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_sweep_seq.sv
// tb_bias_sweep_seq: directed scoreboard bench for bias_sweep_seq
module tb_bias_sweep_seq;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] ib_lo = '0, ib_hi = '0, step = '0, diode_mask = '0;
    logic [15:0] dwell = '0;
    logic [7:0] ib, ibf, diode;
    logic [3:0] idac_o;
    logic res_n, busy, done, err;
    typedef struct packed {logic [7:0] ib; logic rn;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    logic exp_rn;
    logic [3:0] exp_idac;

    bias_sweep_seq dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .ib_lo(ib_lo), .ib_hi(ib_hi), .step(step), .dwell(dwell), .diode_mask(diode_mask),
        .ib(ib), .ibf(ibf), .res_n(res_n), .diode(diode), .idac_o(idac_o),
        .busy(busy), .done(done), .err(err)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic [7:0] v, input int n);
        repeat (n) begin
            q.push_back({v, exp_rn});
            exp_rn = ~exp_rn;
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] st, input logic [15:0] dw);
        mode = m; ib_lo = lo; ib_hi = hi; step = st; dwell = dw; diode_mask = 8'hA5;
    endtask

    task automatic run(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] st, input logic [15:0] dw);
        exp_t e;
        int n = 0;
        logic [7:0] last = '0;
        cfg(m, lo, hi, st, dw);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("run_diode", diode, 8'hA5);
        while (q.size() > 0) begin
            e = q.pop_front();
            last = e.ib;
            check("run_busy", busy, 1'b1);
            check("run_ib", ib, e.ib);
            check("run_res_n", res_n, e.rn);
            tick;
            n++;
        end
        exp_idac = exp_idac + 4'd1;
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_idac", idac_o, exp_idac);
        check("done_ibf", ibf, n[7:0]);
        check("done_ib", ib, last);
        check("done_res_n", res_n, 1'b1);
        tick;
        check("post_done", done, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_ibf", ibf, n[7:0]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick;
        check("rst_ib", ib, 8'h7F);
        check("rst_ibf", ibf, 8'h00);
        check("rst_res_n", res_n, 1'b1);
        check("rst_diode", diode, 8'hFF);
        check("rst_idac", idac_o, 4'd6);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        exp_idac = 4'd6;

        exp_rn = 1'b1;
        seg(8'h10, 3); seg(8'h14, 3); seg(8'h18, 3);
        run(2'd1, 8'h10, 8'h18, 8'd4, 16'd3);

        exp_rn = 1'b1;
        seg(8'd0, 1); seg(8'd2, 1); seg(8'd4, 1); seg(8'd5, 1);
        seg(8'd3, 1); seg(8'd1, 1); seg(8'd0, 1);
        run(2'd3, 8'd0, 8'd5, 8'd2, 16'd1);

        exp_rn = 1'b1;
        seg(8'h0A, 2); seg(8'h06, 2); seg(8'h03, 2);
        run(2'd2, 8'h03, 8'h0A, 8'd4, 16'd2);

        cfg(2'd1, 8'h20, 8'h10, 8'd4, 16'd3);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("bad_err", err, 1'b1);
        check("bad_busy", busy, 1'b0);
        check("bad_ib", ib, 8'h03);
        tick;
        check("bad_err_clr", err, 1'b0);
        check("bad_busy2", busy, 1'b0);
        cfg(2'd1, 8'h01, 8'h02, 8'd0, 16'd3);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("step0_err", err, 1'b1);
        check("step0_busy", busy, 1'b0);
        tick;

        cfg(2'd1, 8'h10, 8'h18, 8'd4, 16'd3);
        start = 1'b1;
        tick;
        check("ab_ib0", ib, 8'h10);
        mode = 2'd2;
        tick;
        start = 1'b0;
        mode = 2'd1;
        check("ab_ign_start", ib, 8'h10);
        tick;
        check("ab_ib2", ib, 8'h10);
        tick;
        check("ab_ib3", ib, 8'h14);
        check("ab_busy", busy, 1'b1);
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        check("ab_ib", ib, 8'h7F);
        check("ab_busy_clr", busy, 1'b0);
        check("ab_done", done, 1'b0);
        check("ab_idac", idac_o, exp_idac);
        check("ab_res_n", res_n, 1'b1);
        tick;
        check("ab_done2", done, 1'b0);
        check("ab_busy2", busy, 1'b0);
        check("ab_ib_hold", ib, 8'h7F);

        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        check("rst2_idac", idac_o, 4'd6);
        exp_idac = 4'd6;
        for (int k = 0; k < 16; k++) begin
            exp_rn = 1'b1;
            seg(8'h33, (k % 3 == 0) ? 1 : k % 3);
            run(2'd0, 8'h33, 8'h40, 8'd0, 16'(k % 3));
        end
        check("wrap_idac", idac_o, 4'd6);

        cfg(2'd0, 8'h22, 8'h40, 8'd0, 16'd20);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("mid_busy", busy, 1'b1);
        check("mid_ib", ib, 8'h22);
        #10 reset = 1'b1;
        #1;
        check("async_ib", ib, 8'h7F);
        check("async_ibf", ibf, 8'h00);
        check("async_busy", busy, 1'b0);
        check("async_res_n", res_n, 1'b1);
        check("async_diode", diode, 8'hFF);
        check("async_idac", idac_o, 4'd6);
        tick;
        reset = 1'b0;
        tick;
        tick;
        check("rel_busy", busy, 1'b0);
        check("rel_ib", ib, 8'h7F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
